// File: rtl/sd_block_loader.sv
// sd_block_loader: pulls NUM_SECTORS 512-byte sectors from an SD controller and packs them into words.
// Latency: a byte is accepted 2 clks after its strobe rises; wr_en follows 1 clk after a word's last byte.
// Backpressure: none on the write port; card side paced by sd_ready/sd_byte_available, TIMEOUT guards stalls.
// Ports: clk, reset_n (async, active-low); start (one-cycle run request);
//        sd_ready/sd_byte_available/sd_dout in, sd_rd/sd_address out (card handshake);
//        wr_en/wr_addr/wr_word (word write port); busy/loaded/error (run status).
module sd_block_loader #(
  parameter int          WORD_BYTES  = 4,
  parameter int          NUM_SECTORS = 16,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter bit          BIG_ENDIAN  = 1'b1,
  parameter int          TIMEOUT     = 1_000_000,
  parameter int          AW          = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    sd_ready,
  input  logic                    sd_byte_available,
  input  logic [7:0]              sd_dout,
  output logic                    sd_rd,
  output logic [31:0]             sd_address,
  output logic                    wr_en,
  output logic [AW-1:0]           wr_addr,
  output logic [8*WORD_BYTES-1:0] wr_word,
  output logic                    busy,
  output logic                    loaded,
  output logic                    error
);

  localparam int WW = 8 * WORD_BYTES;
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_XFER,
    S_DONE,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          r_bav_q1;
  logic          r_bav_q2;
  logic [7:0]    r_dout_q;
  logic [15:0]   r_sector;
  logic [8:0]    r_byte_cnt;
  logic          r_sec_done;
  logic [BW-1:0] r_wb_cnt;
  logic [WW-1:0] r_shift;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [WW-1:0] r_wr_word;
  logic [TW-1:0] r_to_cnt;

  logic          w_busy;
  logic          w_start_ok;
  logic          w_byte_edge;
  logic          w_accept;
  logic          w_last_byte;
  logic          w_last_sector;
  logic          w_word_full;
  logic          w_timeout;
  logic [WW-1:0] w_byte_ext;
  logic [WW-1:0] w_shift_nxt;

  assign w_busy        = (r_state == S_ISSUE) || (r_state == S_ACK) || (r_state == S_XFER);
  assign w_start_ok    = start && !w_busy;
  // Strobe and data are registered together, so r_dout_q is the byte belonging to the edge.
  assign w_byte_edge   = r_bav_q1 && !r_bav_q2;
  // Once byte 511 is in, r_sec_done blocks any overrun bytes until the next ISSUE.
  assign w_accept      = w_byte_edge && ((r_state == S_ACK) || ((r_state == S_XFER) && !r_sec_done));
  assign w_last_byte   = (r_byte_cnt == 9'd511);
  assign w_last_sector = (r_sector == 16'(NUM_SECTORS - 1));
  assign w_word_full   = (r_wb_cnt == BW'(WORD_BYTES - 1));
  assign w_timeout     = w_busy && (r_to_cnt == TW'(TIMEOUT));

  assign w_byte_ext  = WW'(r_dout_q);
  assign w_shift_nxt = BIG_ENDIAN ? ((r_shift << 8) | w_byte_ext)
                                  : ((r_shift >> 8) | (w_byte_ext << (WW - 8)));

  assign sd_rd      = (r_state == S_ISSUE) && sd_ready;
  assign sd_address = BASE_ADR + {7'd0, r_sector, 9'd0};
  assign busy       = w_busy;
  assign loaded     = (r_state == S_DONE);
  assign error      = (r_state == S_ERR);
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_word    = r_wr_word;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_state_nxt = S_ISSUE;
      S_ISSUE:               if (!sd_ready) w_state_nxt = S_ACK;
      S_ACK:                 if (w_accept) w_state_nxt = S_XFER;
      S_XFER: begin
        // Leaving one clk after byte 511 lets the final wr_en go out before loaded rises.
        if (r_sec_done) begin
          if (w_last_sector)  w_state_nxt = S_DONE;
          else if (sd_ready)  w_state_nxt = S_ISSUE;
        end
      end
      default:               w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) w_state_nxt = S_ERR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_bav_q1   <= 1'b0;
      r_bav_q2   <= 1'b0;
      r_dout_q   <= '0;
      r_sector   <= '0;
      r_byte_cnt <= '0;
      r_sec_done <= 1'b0;
      r_wb_cnt   <= '0;
      r_shift    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_word  <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bav_q1 <= sd_byte_available;
      r_bav_q2 <= r_bav_q1;
      r_dout_q <= sd_dout;
      r_wr_en  <= 1'b0;

      // Address advances after the pulse so wr_addr is stable while wr_en is high.
      if (r_wr_en) r_wr_addr <= r_wr_addr + AW'(1);

      if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 9'd1;
        r_shift    <= w_shift_nxt;
        if (w_word_full) begin
          r_wb_cnt  <= '0;
          r_wr_en   <= 1'b1;
          r_wr_word <= w_shift_nxt;
        end else begin
          r_wb_cnt <= r_wb_cnt + BW'(1);
        end
        if (w_last_byte) r_sec_done <= 1'b1;
      end

      if ((r_state == S_XFER) && (w_state_nxt == S_ISSUE)) begin
        r_sector   <= r_sector + 16'd1;
        r_sec_done <= 1'b0;
      end

      // A stalled card loses its partial word, including one completed in the same clk.
      if (w_timeout) begin
        r_wb_cnt <= '0;
        r_shift  <= '0;
        r_wr_en  <= 1'b0;
      end

      if (w_start_ok) begin
        r_sector   <= '0;
        r_byte_cnt <= '0;
        r_sec_done <= 1'b0;
        r_wb_cnt   <= '0;
        r_shift    <= '0;
        r_wr_addr  <= '0;
      end

      if (w_accept || (w_state_nxt != r_state) || !w_busy) r_to_cnt <= '0;
      else                                                  r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_sd_block_loader.sv
`timescale 1ns/1ps
module tb_sd_block_loader;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        sd_ready;
  logic        card_bav;
  logic        tb_bav = 1'b0;
  logic        bav;
  logic [7:0]  sd_dout;

  logic        sd_rd_a, wr_en_a, busy_a, loaded_a, error_a;
  logic [31:0] sd_address_a;
  logic [15:0] wr_addr_a;
  logic [31:0] wr_word_a;

  logic        sd_rd_b, wr_en_b, busy_b, loaded_b, error_b;
  logic [31:0] sd_address_b;
  logic [15:0] wr_addr_b;
  logic [15:0] wr_word_b;

  assign bav = card_bav | tb_bav;

  sd_block_loader #(.TIMEOUT(50)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .sd_ready(sd_ready),
    .sd_byte_available(bav), .sd_dout(sd_dout), .sd_rd(sd_rd_a),
    .sd_address(sd_address_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_word(wr_word_a), .busy(busy_a), .loaded(loaded_a), .error(error_a)
  );

  sd_block_loader #(.WORD_BYTES(2), .NUM_SECTORS(1), .BIG_ENDIAN(1'b0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .sd_ready(sd_ready),
    .sd_byte_available(bav), .sd_dout(sd_dout), .sd_rd(sd_rd_b),
    .sd_address(sd_address_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_word(wr_word_b), .busy(busy_b), .loaded(loaded_b), .error(error_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Card model shared by both DUTs; sel picks whose read request it answers.
  logic        sel = 1'b0;
  logic        card_abort = 1'b0;
  int          stall_sec = -1;
  int          stall_byte = -1;
  int          rise_cyc = 0;
  logic        stalled = 1'b0;
  logic        card_rd;
  logic [31:0] card_addr;
  assign card_rd   = sel ? sd_rd_b : sd_rd_a;
  assign card_addr = sel ? sd_address_b : sd_address_a;

  initial begin
    sd_ready = 1'b1;
    card_bav = 1'b0;
    sd_dout  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (card_rd && sd_ready && !card_abort) begin
        int sec;
        sec = int'(card_addr >> 9);
        sd_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 512 && !card_abort; i++) begin
          if (sec == stall_sec && i == stall_byte) begin
            stalled = 1'b1;
            while (!card_abort) begin @(posedge clk); #1; end
            stalled = 1'b0;
          end else begin
            sd_dout  = 8'(i);
            card_bav = 1'b1;
            rise_cyc = cyc;
            repeat (3) begin @(posedge clk); #1; end
            card_bav = 1'b0;
            @(posedge clk); #1;
          end
        end
        sd_ready = 1'b1;
      end
    end
  end

  // Word/address scoreboard: expected words follow the card's 00..FF byte pattern.
  int cnt_a = 0, base_a = 0;
  int cnt_b = 0, base_b = 0;

  function automatic logic [31:0] exp_a(input int k);
    return {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
  endfunction

  function automatic logic [15:0] exp_b(input int k);
    return {8'(2*k+1), 8'(2*k)};
  endfunction

  always @(negedge clk) begin
    if (wr_en_a) begin
      chk("wordA", wr_word_a, exp_a(cnt_a - base_a));
      chk("addrA", wr_addr_a, 16'(cnt_a - base_a));
      cnt_a++;
    end
    if (sd_rd_a) chk("sdaddrA", sd_address_a, 32'(((cnt_a - base_a) / 128) * 512));
    if (wr_en_b) begin
      chk("wordB", wr_word_b, exp_b(cnt_b - base_b));
      chk("addrB", wr_addr_b, 16'(cnt_b - base_b));
      cnt_b++;
    end
    if (sd_rd_b) chk("sdaddrB", sd_address_b, 32'h0);
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(input bit which_b);
    @(posedge clk); #1;
    if (which_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic abort_card();
    card_abort = 1'b1;
    repeat (10) tick();
    card_abort = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sd_rd"},   sd_rd_a, 1'b0);
    chk({tag, "_wr_en"},   wr_en_a, 1'b0);
    chk({tag, "_wr_addr"}, wr_addr_a, 16'h0);
    chk({tag, "_wr_word"}, wr_word_a, 32'h0);
    chk({tag, "_sd_addr"}, sd_address_a, 32'h0);
    chk({tag, "_busy"},    busy_a, 1'b0);
    chk({tag, "_loaded"},  loaded_a, 1'b0);
    chk({tag, "_error"},   error_a, 1'b0);
  endtask

  initial begin
    int snap;

    // Reset state
    repeat (2) tick();
    check_reset_vals("rst");
    reset_n = 1'b1;
    repeat (3) tick();

    // Full default-style run, start pulsed mid-run while busy
    base_a = cnt_a;
    pulse_start(1'b0);
    tick();
    chk("busy_after_start", busy_a, 1'b1);
    for (int n = 0; n < 20000 && (cnt_a - base_a) < 300; n++) tick();
    pulse_start(1'b0);
    tick();
    chk("busy_after_restart_attempt", busy_a, 1'b1);
    for (int n = 0; n < 60000 && !loaded_a; n++) tick();
    chk("loadedA", loaded_a, 1'b1);
    chk("wordsA", 32'(cnt_a - base_a), 32'd2048);
    chk("busy_doneA", busy_a, 1'b0);
    chk("wr_addr_doneA", wr_addr_a, 16'd2048);

    // Stray strobes in DONE are ignored
    snap = cnt_a;
    for (int k = 0; k < 5; k++) begin
      tb_bav = 1'b1; repeat (2) tick();
      tb_bav = 1'b0; repeat (2) tick();
    end
    chk("done_strobe_words", 32'(cnt_a), 32'(snap));
    chk("done_strobe_addr", wr_addr_a, 16'd2048);
    chk("done_loaded_held", loaded_a, 1'b1);
    chk("done_sd_rd", sd_rd_a, 1'b0);

    // Card stalls after byte 100 of sector 2
    stall_sec  = 2;
    stall_byte = 101;
    base_a = cnt_a;
    pulse_start(1'b0);
    chk("loaded_cleared", loaded_a, 1'b0);
    for (int n = 0; n < 20000 && !stalled; n++) tick();
    chk("stall_seen", stalled, 1'b1);
    for (int n = 0; n < 200 && cyc < rise_cyc + 52; n++) tick();
    chk("pre_timeout_err", error_a, 1'b0);
    chk("pre_timeout_busy", busy_a, 1'b1);
    tick();
    chk("timeout_err", error_a, 1'b1);
    chk("timeout_busy", busy_a, 1'b0);
    chk("timeout_loaded", loaded_a, 1'b0);
    chk("timeout_words", 32'(cnt_a - base_a), 32'd281);
    repeat (20) tick();
    chk("after_timeout_words", 32'(cnt_a - base_a), 32'd281);
    chk("err_sticky", error_a, 1'b1);
    stall_sec  = -1;
    stall_byte = -1;
    abort_card();

    // New start clears error; then reset mid-sector 5
    base_a = cnt_a;
    pulse_start(1'b0);
    tick();
    chk("err_cleared", error_a, 1'b0);
    chk("busy_restart", busy_a, 1'b1);
    for (int n = 0; n < 30000 && (cnt_a - base_a) < 5*128 + 10; n++) tick();
    chk("sector5_addr", sd_address_a, 32'd2560);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    card_abort = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    snap = cnt_a;
    repeat (10) tick();
    card_abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tb_bav = 1'b1; repeat (2) tick();
      tb_bav = 1'b0; repeat (2) tick();
    end
    chk("no_wr_after_rst", 32'(cnt_a), 32'(snap));
    chk("idle_after_rst", busy_a, 1'b0);

    // Restart from sector 0, word 0
    base_a = cnt_a;
    pulse_start(1'b0);
    tick();
    chk("restart_sd_addr", sd_address_a, 32'h0);
    for (int n = 0; n < 2000 && (cnt_a - base_a) < 10; n++) tick();
    chk("restart_progress", 32'(cnt_a - base_a), 32'd10);
    reset_n = 1'b0;
    card_abort = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    card_abort = 1'b0;
    repeat (2) tick();

    // Little-endian, 16-bit words, one sector
    sel = 1'b1;
    snap = cnt_a;
    base_b = cnt_b;
    pulse_start(1'b1);
    for (int n = 0; n < 10000 && !loaded_b; n++) tick();
    chk("loadedB", loaded_b, 1'b1);
    chk("wordsB", 32'(cnt_b - base_b), 32'd256);
    chk("wr_addr_doneB", wr_addr_b, 16'd256);
    chk("sd_addrB", sd_address_b, 32'h0);
    chk("errorB", error_b, 1'b0);
    chk("A_quiet_during_B", 32'(cnt_a), 32'(snap));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_block_loader.md
SD_BLOCK_LOADER -- requirements
Module: sd_block_loader

Interface
REQ-001 Parameter WORD_BYTES, default 4, bytes per assembled word; legal values 1, 2, 4, 8.
REQ-002 Parameter NUM_SECTORS, default 16, number of 512-byte sectors loaded per run; range 1..65535.
REQ-003 Parameter BASE_ADR, default 32'h0000_0000, byte address of the first sector; multiple of 512.
REQ-004 Parameter BIG_ENDIAN, default 1; 1 = first byte read lands in the word MSB, 0 = first byte lands in the LSB.
REQ-005 Parameter TIMEOUT, default 1_000_000, idle cycles allowed between card events before an error is flagged.
REQ-006 Parameter AW, default 16, width of the word write address.
REQ-007 clk  in  1  single clock, 25 MHz, shared with the SD controller.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle request that begins a load run.
REQ-010 sd_ready  in  1  SD controller idle and able to accept a read.
REQ-011 sd_byte_available  in  1  SD controller byte strobe; each 0->1 edge is one new byte.
REQ-012 sd_dout  in  8  SD controller read byte.
REQ-013 sd_rd  out  1  read request to the SD controller.
REQ-014 sd_address  out  32  sector byte address presented to the SD controller.
REQ-015 wr_en  out  1  one-cycle strobe; wr_word is valid for wr_addr.
REQ-016 wr_addr  out  AW  global word index, counted from 0.
REQ-017 wr_word  out  8*WORD_BYTES  assembled word.
REQ-018 busy  out  1  high while a run is in progress.
REQ-019 loaded  out  1  high once all NUM_SECTORS have been written; held until the next start or reset.
REQ-020 error  out  1  sticky timeout flag; cleared by start or reset.

Function
REQ-021 States: IDLE, ISSUE, ACK, XFER, DONE, ERR.
REQ-022 IDLE: start=1 -> ISSUE; sector index <= 0; wr_addr <= 0; loaded <= 0; error <= 0.
REQ-023 ISSUE: sd_address = BASE_ADR + 512*sector index; sd_rd=1 while sd_ready=1; go to ACK on the first cycle sd_ready=0.
REQ-024 ACK/XFER: sd_rd=0; a byte is accepted on the cycle a registered sd_byte_available transitions from 0 to 1; a level held high counts as exactly one byte.
REQ-025 Bytes are shifted into the word according to BIG_ENDIAN. After WORD_BYTES bytes, wr_en pulses for 1 cycle on the next clk with the completed word; wr_addr increments in the cycle after the pulse.
REQ-026 XFER counts bytes 0..511 with a 9-bit counter. After byte 511: if sector index = NUM_SECTORS-1 -> DONE, otherwise increment the sector index and wait for sd_ready=1, then -> ISSUE.
REQ-027 Bytes arriving after byte 511 of a sector, or arriving in IDLE or DONE, are ignored; no wr_en is generated for them.
REQ-028 DONE: loaded=1, busy=0; start=1 begins a new run exactly as from IDLE.
REQ-029 busy=1 in ISSUE, ACK and XFER only; start while busy is ignored.
REQ-030 Timeout counter: clears on every accepted byte and every state change; counts in ISSUE, ACK and XFER; on reaching TIMEOUT -> ERR with error=1, sd_rd=0, and any partial word discarded.
REQ-031 ERR: busy=0, loaded=0; start=1 -> same entry as from IDLE.
REQ-032 Total words written per run = NUM_SECTORS*512/WORD_BYTES; wr_addr wraps modulo 2^AW with no flag.
REQ-033 At most one wr_en per clk; sd_rd never asserts outside ISSUE.

Reset
REQ-034 reset_n=0 asynchronously forces IDLE and sets sd_rd=0, wr_en=0, wr_addr=0, wr_word=0, sd_address=BASE_ADR, busy=0, loaded=0, error=0, and clears all counters.
REQ-035 Reset during a transfer discards the partial word and the sector progress; no wr_en is emitted after reset_n rises until a new start.

Verification
REQ-036 Defaults, card model returning bytes 00..FF repeating, 16 sectors -> 2048 wr_en pulses; word 0 = 32'h00010203; loaded=1 after the last pulse.
REQ-037 BIG_ENDIAN=0, WORD_BYTES=2, NUM_SECTORS=1 -> 256 pulses; word 0 = 16'h0100; sd_address stays 0.
REQ-038 sd_byte_available held high for 3 cycles per byte -> counted once per byte; word count is unchanged from REQ-036.
REQ-039 Card stalls after byte 100 of sector 2, TIMEOUT=50 -> error=1 and busy=0 51 cycles after the last byte; no further wr_en; a new start clears error.
REQ-040 reset_n pulsed low mid-sector 5 -> outputs at their reset values immediately; a new start restarts at sd_address=BASE_ADR with wr_addr=0.
REQ-041 start pulsed while busy, and extra strobes issued in DONE -> no effect on state, wr_addr or wr_en.
